// File: rtl/tile_map_arbiter.sv
// rtl/tile_map_arbiter.sv - round-robin arbiter and clear engine for the shared tile-map port
module tile_map_arbiter #(
    parameter int AW        = 13,
    parameter int DW        = 8,
    parameter int RD_LAT    = 1,
    parameter int CLR_WORDS = 8192
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_start,
    input  logic [DW-1:0] clr_val,
    output logic          clr_busy,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_adr,
    input  logic [DW-1:0] a_wdat,
    output logic          a_ack,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdat,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_adr,
    input  logic [DW-1:0] b_wdat,
    output logic          b_ack,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdat,
    output logic [AW-1:0] tm_adr,
    output logic [DW-1:0] tm_wrt,
    output logic          tm_wen,
    input  logic [DW-1:0] tm_red
);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    localparam logic [AW:0] CLR_LAST = (AW+1)'(CLR_WORDS - 1);

    state_t        state, state_nxt;
    logic [AW:0]   cnt, cnt_nxt;
    logic [DW-1:0] clr_reg, clr_reg_nxt;
    logic          clr_issue;
    logic          last_a;
    logic          grant_ok;
    logic          rd_issue;
    logic [RD_LAT:0] pipe_v;
    logic [RD_LAT:0] pipe_id;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        clr_reg_nxt = clr_reg;
        clr_issue   = 1'b0;
        case (state)
            S_IDLE: begin
                if (clr_start) begin
                    state_nxt   = S_CLEAR;
                    cnt_nxt     = '0;
                    clr_reg_nxt = clr_val;
                end
            end
            S_CLEAR: begin
                clr_issue = 1'b1;
                cnt_nxt   = cnt + (AW+1)'(1);
                if (cnt == CLR_LAST) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign clr_busy = (state == S_CLEAR);

    // A clear request starting this cycle takes the port ahead of either requester.
    assign grant_ok = !rst && (state == S_IDLE) && !clr_start;
    assign a_ack    = grant_ok && a_req && (!b_req || !last_a);
    assign b_ack    = grant_ok && b_req && (!a_req || last_a);
    assign rd_issue = (a_ack && !a_we) || (b_ack && !b_we);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            clr_reg <= '0;
            last_a  <= 1'b0;
            tm_wen  <= 1'b0;
            tm_adr  <= '0;
            tm_wrt  <= '0;
            pipe_v  <= '0;
            pipe_id <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            clr_reg <= clr_reg_nxt;
            if (a_ack) begin
                last_a <= 1'b1;
            end else if (b_ack) begin
                last_a <= 1'b0;
            end
            if (clr_issue) begin
                tm_wen <= 1'b1;
                tm_adr <= cnt[AW-1:0];
                tm_wrt <= clr_reg;
            end else if (a_ack) begin
                tm_wen <= a_we;
                tm_adr <= a_adr;
                tm_wrt <= a_wdat;
            end else if (b_ack) begin
                tm_wen <= b_we;
                tm_adr <= b_adr;
                tm_wrt <= b_wdat;
            end else begin
                tm_wen <= 1'b0;
            end
            // Stage k is visible k+1 cycles after the ack edge; the last stage lines up with tm_red.
            pipe_v  <= {pipe_v[RD_LAT-1:0], rd_issue};
            pipe_id <= {pipe_id[RD_LAT-1:0], b_ack};
        end
    end

    assign a_rvalid = pipe_v[RD_LAT] && !pipe_id[RD_LAT];
    assign b_rvalid = pipe_v[RD_LAT] && pipe_id[RD_LAT];
    assign a_rdat   = tm_red;
    assign b_rdat   = tm_red;

endmodule

// File: tb/tb_tile_map_arbiter.sv
// tb/tb_tile_map_arbiter.sv - scoreboard bench for tile_map_arbiter
module tb_tile_map_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_start;
    logic [7:0]  clr_val;
    logic        clr_busy;
    logic        a_req, a_we, a_ack, a_rvalid;
    logic [12:0] a_adr;
    logic [7:0]  a_wdat, a_rdat;
    logic        b_req, b_we, b_ack, b_rvalid;
    logic [12:0] b_adr;
    logic [7:0]  b_wdat, b_rdat;
    logic [12:0] tm_adr;
    logic [7:0]  tm_wrt;
    logic        tm_wen;
    logic [7:0]  tm_red;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [20:0] exp_wr[$];
    int          exp_a_cyc[$];
    logic [7:0]  exp_a_dat[$];
    int          exp_b_cyc[$];
    logic [7:0]  exp_b_dat[$];
    int          ack_log[$];

    tile_map_arbiter #(.AW(13), .DW(8), .RD_LAT(1), .CLR_WORDS(16)) dut (
        .clk(clk), .rst(rst),
        .clr_start(clr_start), .clr_val(clr_val), .clr_busy(clr_busy),
        .a_req(a_req), .a_we(a_we), .a_adr(a_adr), .a_wdat(a_wdat),
        .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdat(a_rdat),
        .b_req(b_req), .b_we(b_we), .b_adr(b_adr), .b_wdat(b_wdat),
        .b_ack(b_ack), .b_rvalid(b_rvalid), .b_rdat(b_rdat),
        .tm_adr(tm_adr), .tm_wrt(tm_wrt), .tm_wen(tm_wen), .tm_red(tm_red)
    );

    always #5 clk = ~clk;

    // Video model: one-cycle read latency, returns the low address byte.
    always @(posedge clk) tm_red <= tm_adr[7:0];
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a write or read data.
    always @(negedge clk) begin
        if (a_ack || b_ack) check("one_ack", {31'b0, a_ack && b_ack}, 32'd0);
        if (tm_wen) begin
            if (exp_wr.size() == 0) begin
                check("unexpected_write", {19'b0, tm_adr}, 32'hFFFF_FFFF);
            end else begin
                logic [20:0] e;
                e = exp_wr.pop_front();
                check("wr_adr", {19'b0, tm_adr}, {19'b0, e[20:8]});
                check("wr_dat", {24'b0, tm_wrt}, {24'b0, e[7:0]});
            end
        end
        if (a_rvalid) begin
            if (exp_a_cyc.size() == 0) begin
                check("unexpected_a_rvalid", 32'd1, 32'd0);
            end else begin
                check("a_rvalid_cycle", cyc, exp_a_cyc.pop_front());
                check("a_rdat", {24'b0, a_rdat}, {24'b0, exp_a_dat.pop_front()});
            end
        end
        if (b_rvalid) begin
            if (exp_b_cyc.size() == 0) begin
                check("unexpected_b_rvalid", 32'd1, 32'd0);
            end else begin
                check("b_rvalid_cycle", cyc, exp_b_cyc.pop_front());
                check("b_rdat", {24'b0, b_rdat}, {24'b0, exp_b_dat.pop_front()});
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that performed the transfer.
    task automatic access(input int id, input logic we, input logic [12:0] adr,
                          input logic [7:0] wd, input int max_wait);
        int n;
        logic got;
        if (id == 0) begin a_req = 1'b1; a_we = we; a_adr = adr; a_wdat = wd; end
        else         begin b_req = 1'b1; b_we = we; b_adr = adr; b_wdat = wd; end
        n = 0;
        got = 1'b0;
        while (!got && n < max_wait) begin
            @(negedge clk);
            got = (id == 0) ? a_ack : b_ack;
            n++;
        end
        if (!got) begin
            check("ack_timeout", id, 32'hFFFF_FFFF);
        end else begin
            ack_log.push_back(id);
            if (we) exp_wr.push_back({adr, wd});
            else if (id == 0) begin exp_a_cyc.push_back(cyc + 2); exp_a_dat.push_back(adr[7:0]); end
            else begin exp_b_cyc.push_back(cyc + 2); exp_b_dat.push_back(adr[7:0]); end
        end
        @(posedge clk); #1;
        if (id == 0) a_req = 1'b0; else b_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_a_cyc.delete(); exp_a_dat.delete();
        exp_b_cyc.delete(); exp_b_dat.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        logic got_ack;

        rst = 1'b1; clr_start = 1'b0; clr_val = 8'h00;
        a_req = 1'b1; a_we = 1'b0; a_adr = 13'h0100; a_wdat = 8'h00;
        b_req = 1'b1; b_we = 1'b0; b_adr = 13'h0200; b_wdat = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_a_ack", {31'b0, a_ack}, 32'd0);
        check("rst_b_ack", {31'b0, b_ack}, 32'd0);
        check("rst_tm_wen", {31'b0, tm_wen}, 32'd0);
        check("rst_tm_adr", {19'b0, tm_adr}, 32'd0);
        check("rst_clr_busy", {31'b0, clr_busy}, 32'd0);
        @(posedge clk); #1;
        a_req = 1'b0; b_req = 1'b0; rst = 1'b0;

        // Single A write: ack in cycle 0, issue visible in cycle 1, gone in cycle 2.
        @(posedge clk); #1;
        a_req = 1'b1; a_we = 1'b1; a_adr = 13'h0010; a_wdat = 8'h5A;
        @(negedge clk);
        check("wr_ack_c0", {31'b0, a_ack}, 32'd1);
        exp_wr.push_back({13'h0010, 8'h5A});
        @(posedge clk); #1 a_req = 1'b0;
        @(negedge clk);
        check("wr_tm_wen_c1", {31'b0, tm_wen}, 32'd1);
        check("wr_tm_adr_c1", {19'b0, tm_adr}, 32'h0010);
        check("wr_tm_wrt_c1", {24'b0, tm_wrt}, 32'h5A);
        check("wr_ack_c1", {31'b0, a_ack}, 32'd0);
        @(negedge clk);
        check("wr_tm_wen_c2", {31'b0, tm_wen}, 32'd0);
        @(posedge clk); #1;

        // Both requesters read continuously: grants alternate starting with A.
        do_reset();
        ack_log.delete();
        fork
            begin
                for (int i = 0; i < 4; i++) access(0, 1'b0, 13'h0A00 + 13'(i * 3 + 1), 8'h00, 10);
            end
            begin
                for (int j = 0; j < 4; j++) access(1, 1'b0, 13'h1B00 + 13'(j * 5 + 2), 8'h00, 10);
            end
        join
        check("rr_ack_count", ack_log.size(), 32'd8);
        for (int k = 0; k < 8 && k < ack_log.size(); k++) check("rr_order", ack_log[k], k % 2);
        repeat (4) @(posedge clk); #1;

        // Clear with a simultaneous A request and a mid-clear restart attempt.
        clr_start = 1'b1; clr_val = 8'h20;
        a_req = 1'b1; a_we = 1'b1; a_adr = 13'h0055; a_wdat = 8'h77;
        for (int k = 0; k < 16; k++) exp_wr.push_back({13'(k), 8'h20});
        @(negedge clk);
        check("clr_tie_a_ack", {31'b0, a_ack}, 32'd0);
        check("clr_busy_c0", {31'b0, clr_busy}, 32'd0);
        busy_cnt = 0;
        got_ack = 1'b0;
        for (int c = 1; c < 40 && !got_ack; c++) begin
            @(posedge clk); #1;
            clr_start = (c == 5);
            clr_val = (c == 5) ? 8'h33 : 8'h20;
            @(negedge clk);
            if (clr_busy) busy_cnt++;
            if (a_ack) begin
                got_ack = 1'b1;
                check("clr_ack_after_busy", {31'b0, clr_busy}, 32'd0);
                exp_wr.push_back({13'h0055, 8'h77});
            end
        end
        @(posedge clk); #1;
        a_req = 1'b0; clr_start = 1'b0;
        check("clr_a_ack_seen", {31'b0, got_ack}, 32'd1);
        check("clr_busy_cycles", busy_cnt, 32'd16);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("clr_writes_done", exp_wr.size(), 32'd0);
        @(posedge clk); #1;

        // Read acked, reset the next cycle: no rvalid may ever follow.
        access(0, 1'b0, 13'h1234, 8'h00, 10);
        do_reset();
        @(negedge clk);
        check("rst2_tm_wen", {31'b0, tm_wen}, 32'd0);
        check("rst2_tm_adr", {19'b0, tm_adr}, 32'd0);
        check("rst2_clr_busy", {31'b0, clr_busy}, 32'd0);
        repeat (5) @(posedge clk); #1;

        // Read accepted, clear starts the next cycle: read data still returns.
        a_req = 1'b1; a_we = 1'b0; a_adr = 13'h00AB;
        @(negedge clk);
        check("rd_clr_ack", {31'b0, a_ack}, 32'd1);
        exp_a_cyc.push_back(cyc + 2); exp_a_dat.push_back(8'hAB);
        @(posedge clk); #1;
        a_req = 1'b0; clr_start = 1'b1; clr_val = 8'h44;
        for (int k = 0; k < 16; k++) exp_wr.push_back({13'(k), 8'h44});
        @(posedge clk); #1 clr_start = 1'b0;
        @(negedge clk);
        check("rd_clr_rvalid", {31'b0, a_rvalid}, 32'd1);
        check("rd_clr_busy", {31'b0, clr_busy}, 32'd1);
        repeat (25) @(posedge clk);
        @(negedge clk);
        check("end_wr_queue", exp_wr.size(), 32'd0);
        check("end_a_queue", exp_a_cyc.size(), 32'd0);
        check("end_b_queue", exp_b_cyc.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
